// File: rtl/ps2_key_pkg.sv
// Shared PS/2 note-key definitions: receiver FSM states, prefix codes and the
// scan-code/ASCII note map also used by the tone rate divider.
package ps2_key_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_e;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    // Sharps
    localparam logic [7:0] SC_W = 8'h1D;
    localparam logic [7:0] SC_E = 8'h24;
    localparam logic [7:0] SC_T = 8'h2C;
    localparam logic [7:0] SC_Y = 8'h35;
    localparam logic [7:0] SC_U = 8'h3C;
    // Naturals
    localparam logic [7:0] SC_A = 8'h1C;
    localparam logic [7:0] SC_S = 8'h1B;
    localparam logic [7:0] SC_D = 8'h23;
    localparam logic [7:0] SC_F = 8'h2B;
    localparam logic [7:0] SC_G = 8'h34;
    localparam logic [7:0] SC_H = 8'h33;
    localparam logic [7:0] SC_J = 8'h3B;

    localparam logic [6:0] ASCII_W = 7'd87;
    localparam logic [6:0] ASCII_E = 7'd69;
    localparam logic [6:0] ASCII_T = 7'd84;
    localparam logic [6:0] ASCII_Y = 7'd89;
    localparam logic [6:0] ASCII_U = 7'd85;
    localparam logic [6:0] ASCII_A = 7'd65;
    localparam logic [6:0] ASCII_S = 7'd83;
    localparam logic [6:0] ASCII_D = 7'd68;
    localparam logic [6:0] ASCII_F = 7'd70;
    localparam logic [6:0] ASCII_G = 7'd71;
    localparam logic [6:0] ASCII_H = 7'd72;
    localparam logic [6:0] ASCII_J = 7'd74;

    // Returns 0 for any code that is not a note key.
    function automatic logic [6:0] scan_to_ascii(input logic [7:0] code);
        case (code)
            SC_W:    return ASCII_W;
            SC_E:    return ASCII_E;
            SC_T:    return ASCII_T;
            SC_Y:    return ASCII_Y;
            SC_U:    return ASCII_U;
            SC_A:    return ASCII_A;
            SC_S:    return ASCII_S;
            SC_D:    return ASCII_D;
            SC_F:    return ASCII_F;
            SC_G:    return ASCII_G;
            SC_H:    return ASCII_H;
            SC_J:    return ASCII_J;
            default: return 7'd0;
        endcase
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: pin synchronisers, falling-edge detect, 11-bit frame FSM
// and inter-edge timeout. Parity is enforced only when PS2_PARITY_CHECK_EN is defined.
module ps2_rx_frame
    import ps2_key_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_done,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    rx_state_e     state_q, state_d;
    logic [1:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    data_sync_q, data_sync_d;
    logic          clk_prev_q, clk_prev_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    byte_q, byte_d;
    logic          byte_done_q, byte_done_d;
    logic          frame_err_q, frame_err_d;

    logic fall;
    logic bit_in;
    logic stop_ok;

    assign fall   = clk_prev_q & ~clk_sync_q[1];
    assign bit_in = data_sync_q[1];

`ifdef PS2_PARITY_CHECK_EN
    assign stop_ok = bit_in & (^{shift_q, parity_q});
`else
    assign stop_ok = bit_in;
`endif

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        clk_sync_d  = {clk_sync_q[0], ps2_clk};
        data_sync_d = {data_sync_q[0], ps2_data};
        clk_prev_d  = clk_sync_q[1];
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        tmo_d       = tmo_q;
        byte_d      = byte_q;
        byte_done_d = 1'b0;
        frame_err_d = 1'b0;

        if (fall) begin
            tmo_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (!bit_in) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                ST_DATA: begin
                    shift_d   = {bit_in, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    parity_d = bit_in;
                    state_d  = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (stop_ok) begin
                        byte_d      = shift_q;
                        byte_done_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            // A stalled partial frame is dropped; an edge in the same cycle takes priority above.
            if (tmo_q == TMO_LAST) begin
                state_d     = ST_IDLE;
                tmo_d       = '0;
                frame_err_d = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end else begin
            tmo_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            tmo_q       <= '0;
            byte_q      <= '0;
            byte_done_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            tmo_q       <= tmo_d;
            byte_q      <= byte_d;
            byte_done_q <= byte_done_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_byte   = byte_q;
    assign byte_done = byte_done_q;
    assign frame_err = frame_err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// Note-key decoder: tracks break/extended prefixes and holds the ASCII of the
// currently pressed note key (0 = none). Optional parity check: PS2_PARITY_CHECK_EN.
module ps2_key_decoder
    import ps2_key_pkg::*;
#(
    parameter int CLK_HZ         = 50000000,
    parameter int TIMEOUT_CYCLES = CLK_HZ / 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [6:0] ascii,
    output logic       key_valid,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       byte_done;

    ps2_rx_frame #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rx_byte  (rx_byte),
        .byte_done(byte_done),
        .frame_err(frame_err)
    );

    logic [6:0] ascii_q, ascii_d;
    logic       key_valid_q, key_valid_d;
    logic       break_flag_q, break_flag_d;
    logic       ext_flag_q, ext_flag_d;
    logic [6:0] code_ascii;

    assign code_ascii = scan_to_ascii(rx_byte);

    always_comb begin
        ascii_d      = ascii_q;
        key_valid_d  = 1'b0;
        break_flag_d = break_flag_q;
        ext_flag_d   = ext_flag_q;

        if (byte_done) begin
            if (rx_byte == SC_BREAK) begin
                break_flag_d = 1'b1;
            end else if (rx_byte == SC_EXT) begin
                ext_flag_d = 1'b1;
            end else if (ext_flag_q) begin
                ext_flag_d   = 1'b0;
                break_flag_d = 1'b0;
            end else if (break_flag_q) begin
                // Releasing a key other than the held one leaves the output alone.
                break_flag_d = 1'b0;
                if (code_ascii != 7'd0 && code_ascii == ascii_q) begin
                    ascii_d     = 7'd0;
                    key_valid_d = 1'b1;
                end
            end else if (code_ascii != 7'd0 && code_ascii != ascii_q) begin
                ascii_d     = code_ascii;
                key_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ascii_q      <= 7'd0;
            key_valid_q  <= 1'b0;
            break_flag_q <= 1'b0;
            ext_flag_q   <= 1'b0;
        end else begin
            ascii_q      <= ascii_d;
            key_valid_q  <= key_valid_d;
            break_flag_q <= break_flag_d;
            ext_flag_q   <= ext_flag_d;
        end
    end

    assign ascii     = ascii_q;
    assign key_valid = key_valid_q;

endmodule
